// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
//   Bus bundle between the multi-port register file and its users: the decode
//   stage (read ports and allocation) and the writeback stage (write ports).
//
//   Signals (k = read port, p = write port):
//     rd_addr    NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//     rd_data    NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//     rd_pending NRD         addressed register has an outstanding producer
//     wr_en      2           write enables for ports 0 and 1
//     wr_addr0/1 ADDR_W      write addresses
//     wr_data0/1 DATA_W      write data
//     alloc_en   1           mark alloc_addr pending
//     alloc_addr ADDR_W      register to mark pending
//     pend_vec   NREGS       full scoreboard, bit i = Ri pending
//
//   Modports: master = decode/writeback side, slave = register file.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int NRD    = 2
);
    localparam int ADDR_W = $clog2(NREGS);

    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_pending;
    logic [1:0]            wr_en;
    logic [ADDR_W-1:0]     wr_addr0;
    logic [DATA_W-1:0]     wr_data0;
    logic [ADDR_W-1:0]     wr_addr1;
    logic [DATA_W-1:0]     wr_data1;
    logic                  alloc_en;
    logic [ADDR_W-1:0]     alloc_addr;
    logic [NREGS-1:0]      pend_vec;

    modport master (
        output rd_addr, wr_en, wr_addr0, wr_data0, wr_addr1, wr_data1,
               alloc_en, alloc_addr,
        input  rd_data, rd_pending, pend_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr0, wr_data0, wr_addr1, wr_data1,
               alloc_en, alloc_addr,
        output rd_data, rd_pending, pend_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file for the RISC datapath. Two
//   synchronous write ports, NRD combinational read ports, optional hardwired
//   zero R0, optional same-cycle write-to-read bypass and a per-register
//   pending scoreboard used by the issue stage for hazard detection.
//
//   Ports:
//     i_clk  in   rising-edge clock
//     i_rst  in   asynchronous active-high reset
//     bus    slave modport of regfile_mp_if (read, write, alloc, scoreboard)
//
//   Parameters:
//     DATA_W     register width
//     NREGS      number of registers (power of two, >= 4)
//     NRD        number of read ports (1..4)
//     ZERO_R0    1: R0 reads as zero, writes/allocs to R0 dropped
//     BYPASS     1: same-cycle write data forwarded to matching reads
//     INIT_STEP  reset value of Ri is i*INIT_STEP, top register resets to 0
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 16,
    parameter int NRD       = 2,
    parameter int ZERO_R0   = 0,
    parameter int BYPASS    = 1,
    parameter int INIT_STEP = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    regfile_mp_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREGS);

    // Reset image: Ri = i*INIT_STEP truncated to DATA_W, top register = 0.
    function automatic logic [DATA_W-1:0] init_val(input int idx);
        if (idx == NREGS - 1) begin
            return '0;
        end
        return DATA_W'(idx * INIT_STEP);
    endfunction

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pend;
    logic [NREGS-1:0]  w_pend_nxt;

    logic w_we0;
    logic w_we1;
    logic w_alloc;

    // Effective enables. Gating with i_rst keeps the bypass path quiet while
    // reset is held, so reads show the reset image rather than pending writes.
    // With ZERO_R0 any access to R0 is simply discarded.
    always_comb begin
        w_we0   = bus.wr_en[0] & ~i_rst;
        w_we1   = bus.wr_en[1] & ~i_rst;
        w_alloc = bus.alloc_en & ~i_rst;
        if (ZERO_R0 != 0) begin
            if (bus.wr_addr0 == '0)   w_we0   = 1'b0;
            if (bus.wr_addr1 == '0)   w_we1   = 1'b0;
            if (bus.alloc_addr == '0) w_alloc = 1'b0;
        end
    end

    // Register array. Port 1 is written last so it wins a same-address
    // collision with port 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= init_val(i);
            end
        end else begin
            if (w_we0) begin
                r_regs[bus.wr_addr0] <= bus.wr_data0;
            end
            if (w_we1) begin
                r_regs[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    // Scoreboard next state: writes clear, alloc sets afterwards so a
    // same-cycle alloc+write leaves the bit set for the newly issued producer.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_we0) begin
            w_pend_nxt[bus.wr_addr0] = 1'b0;
        end
        if (w_we1) begin
            w_pend_nxt[bus.wr_addr1] = 1'b0;
        end
        if (w_alloc) begin
            w_pend_nxt[bus.alloc_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign bus.pend_vec = r_pend;

    // Combinational read ports. Pending status is deliberately not bypassed:
    // it reflects registered scoreboard state only.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        logic              w_rp;

        assign w_ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_regs[w_ra];
            w_rp = r_pend[w_ra];
            if (BYPASS != 0) begin
                if (w_we1 && (bus.wr_addr1 == w_ra)) begin
                    w_rd = bus.wr_data1;
                end else if (w_we0 && (bus.wr_addr0 == w_ra)) begin
                    w_rd = bus.wr_data0;
                end
            end
            if ((ZERO_R0 != 0) && (w_ra == '0)) begin
                w_rd = '0;
                w_rp = 1'b0;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = w_rd;
        assign bus.rd_pending[k]               = w_rp;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Two instances share one stimulus:
//     dut_a : ZERO_R0=0, BYPASS=1
//     dut_b : ZERO_R0=1, BYPASS=0
//   Expected values are hand-computed constants (INIT_STEP=10, NREGS=16).
// -----------------------------------------------------------------------------
module tb_regfile_mp;
    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [3:0]  wr_addr0;
    logic [31:0] wr_data0;
    logic [3:0]  wr_addr1;
    logic [31:0] wr_data1;
    logic        alloc_en;
    logic [3:0]  alloc_addr;

    int vectors;
    int miscompares;

    regfile_mp_if #(.DATA_W(32), .NREGS(16), .NRD(2)) ifa ();
    regfile_mp_if #(.DATA_W(32), .NREGS(16), .NRD(2)) ifb ();

    assign ifa.rd_addr    = rd_addr;
    assign ifa.wr_en      = wr_en;
    assign ifa.wr_addr0   = wr_addr0;
    assign ifa.wr_data0   = wr_data0;
    assign ifa.wr_addr1   = wr_addr1;
    assign ifa.wr_data1   = wr_data1;
    assign ifa.alloc_en   = alloc_en;
    assign ifa.alloc_addr = alloc_addr;

    assign ifb.rd_addr    = rd_addr;
    assign ifb.wr_en      = wr_en;
    assign ifb.wr_addr0   = wr_addr0;
    assign ifb.wr_data0   = wr_data0;
    assign ifb.wr_addr1   = wr_addr1;
    assign ifb.wr_data1   = wr_data1;
    assign ifb.alloc_en   = alloc_en;
    assign ifb.alloc_addr = alloc_addr;

    regfile_mp #(
        .DATA_W(32), .NREGS(16), .NRD(2),
        .ZERO_R0(0), .BYPASS(1), .INIT_STEP(10)
    ) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa.slave)
    );

    regfile_mp #(
        .DATA_W(32), .NREGS(16), .NRD(2),
        .ZERO_R0(1), .BYPASS(0), .INIT_STEP(10)
    ) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rd_addr     = {4'd9, 4'd1};
        wr_en       = 2'b00;
        wr_addr0    = '0;
        wr_data0    = '0;
        wr_addr1    = '0;
        wr_data1    = '0;
        alloc_en    = 1'b0;
        alloc_addr  = '0;

        // 1: reset contents
        #2;
        chk("a_rst_r1",  ifa.rd_data[31:0],  32'd10);
        chk("a_rst_r9",  ifa.rd_data[63:32], 32'd90);
        chk("b_rst_r1",  ifb.rd_data[31:0],  32'd10);
        chk("b_rst_r9",  ifb.rd_data[63:32], 32'd90);
        rd_addr = {4'd15, 4'd14};
        #1;
        chk("a_rst_r14", ifa.rd_data[31:0],  32'd140);
        chk("a_rst_r15", ifa.rd_data[63:32], 32'd0);
        chk("b_rst_r14", ifb.rd_data[31:0],  32'd140);
        chk("a_rst_pend", 32'(ifa.pend_vec), 32'h0);
        chk("b_rst_pend", 32'(ifb.pend_vec), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 2: single write, bypass vs registered visibility
        wr_en    = 2'b01;
        wr_addr0 = 4'd3;
        wr_data0 = 32'hDEAD_BEEF;
        rd_addr  = {4'd3, 4'd3};
        #1;
        chk("a_wr3_same", ifa.rd_data[31:0], 32'hDEAD_BEEF);
        chk("b_wr3_same", ifb.rd_data[31:0], 32'd30);
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        chk("a_wr3_next", ifa.rd_data[31:0], 32'hDEAD_BEEF);
        chk("b_wr3_next", ifb.rd_data[63:32], 32'hDEAD_BEEF);

        // 3: dual-write collision, port 1 wins
        wr_en    = 2'b11;
        wr_addr0 = 4'd5;
        wr_data0 = 32'h11;
        wr_addr1 = 4'd5;
        wr_data1 = 32'h22;
        rd_addr  = {4'd5, 4'd5};
        #1;
        chk("a_col_byp",  ifa.rd_data[31:0], 32'h22);
        chk("b_col_same", ifb.rd_data[31:0], 32'd50);
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        chk("a_col_r5", ifa.rd_data[63:32], 32'h22);
        chk("b_col_r5", ifb.rd_data[31:0],  32'h22);

        // distinct addresses on the two write ports, each bypassed to its reader
        wr_en    = 2'b11;
        wr_addr0 = 4'd6;
        wr_data0 = 32'h66;
        wr_addr1 = 4'd5;
        wr_data1 = 32'h77;
        rd_addr  = {4'd5, 4'd6};
        #1;
        chk("a_split_p0", ifa.rd_data[31:0],  32'h66);
        chk("a_split_p1", ifa.rd_data[63:32], 32'h77);
        chk("b_split_p0", ifb.rd_data[31:0],  32'd60);
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        chk("b_split_r6", ifb.rd_data[31:0],  32'h66);
        chk("b_split_r5", ifb.rd_data[63:32], 32'h77);

        // 4: scoreboard
        alloc_en   = 1'b1;
        alloc_addr = 4'd7;
        rd_addr    = {4'd7, 4'd7};
        #1;
        chk("a_alloc_before", 32'(ifa.pend_vec), 32'h0);
        @(posedge clk); #1;
        alloc_en = 1'b0;
        #1;
        chk("a_alloc_pend",  32'(ifa.pend_vec),   32'h0080);
        chk("a_alloc_rdp",   32'(ifa.rd_pending), 32'h3);
        chk("b_alloc_pend",  32'(ifb.pend_vec),   32'h0080);
        wr_en    = 2'b01;
        wr_addr0 = 4'd7;
        wr_data0 = 32'h70;
        #1;
        chk("a_clr_notbyp", 32'(ifa.rd_pending), 32'h3);
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        chk("a_clr_pend", 32'(ifa.pend_vec),   32'h0);
        chk("b_clr_rdp",  32'(ifb.rd_pending), 32'h0);

        alloc_en   = 1'b1;
        alloc_addr = 4'd7;
        wr_en      = 2'b10;
        wr_addr1   = 4'd7;
        wr_data1   = 32'h71;
        @(posedge clk); #1;
        alloc_en   = 1'b1;
        alloc_addr = 4'd9;
        wr_en      = 2'b00;
        #1;
        chk("a_allocwr_set", 32'(ifa.pend_vec), 32'h0080);
        chk("b_allocwr_set", 32'(ifb.pend_vec), 32'h0080);
        @(posedge clk); #1;
        alloc_en = 1'b0;
        #1;
        chk("a_two_pend", 32'(ifa.pend_vec), 32'h0280);
        wr_en    = 2'b11;
        wr_addr0 = 4'd7;
        wr_data0 = 32'h07;
        wr_addr1 = 4'd9;
        wr_data1 = 32'h09;
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        chk("a_both_clr", 32'(ifa.pend_vec), 32'h0);
        chk("b_both_clr", 32'(ifb.pend_vec), 32'h0);

        // 5: writes and alloc to R0
        wr_en      = 2'b01;
        wr_addr0   = 4'd0;
        wr_data0   = 32'h55;
        alloc_en   = 1'b1;
        alloc_addr = 4'd0;
        rd_addr    = {4'd0, 4'd0};
        #1;
        chk("a_r0_byp",  ifa.rd_data[31:0], 32'h55);
        chk("b_r0_same", ifb.rd_data[31:0], 32'h0);
        chk("b_r0_pend_same", 32'(ifb.pend_vec), 32'h0);
        @(posedge clk); #1;
        wr_en    = 2'b00;
        alloc_en = 1'b0;
        #1;
        chk("a_r0_next",  ifa.rd_data[63:32], 32'h55);
        chk("a_r0_pend",  32'(ifa.pend_vec),   32'h0001);
        chk("a_r0_rdp",   32'(ifa.rd_pending), 32'h3);
        chk("b_r0_next",  ifb.rd_data[31:0],  32'h0);
        chk("b_r0_pend",  32'(ifb.pend_vec),   32'h0);
        chk("b_r0_rdp",   32'(ifb.rd_pending), 32'h0);

        // 6: async reset between edges with a write pending
        wr_en    = 2'b01;
        wr_addr0 = 4'd2;
        wr_data0 = 32'hABCD;
        rd_addr  = {4'd5, 4'd2};
        #1;
        chk("a_pre_rst_byp", ifa.rd_data[31:0], 32'hABCD);
        #1;
        rst = 1'b1;
        #1;
        chk("a_mid_rst_r2",  ifa.rd_data[31:0],  32'd20);
        chk("b_mid_rst_r2",  ifb.rd_data[31:0],  32'd20);
        chk("a_mid_rst_r5",  ifa.rd_data[63:32], 32'd50);
        chk("a_mid_rst_pend", 32'(ifa.pend_vec), 32'h0);
        @(posedge clk); #1;
        chk("a_held_rst_r2", ifa.rd_data[31:0], 32'd20);
        chk("b_held_rst_r2", ifb.rd_data[31:0], 32'd20);
        #1;
        rst = 1'b0;
        #1;
        chk("a_rel_byp",    ifa.rd_data[31:0], 32'hABCD);
        chk("b_rel_nowr",   ifb.rd_data[31:0], 32'd20);
        wr_en = 2'b00;
        @(posedge clk); #1;
        chk("a_rel_idle_r2", ifa.rd_data[31:0], 32'd20);
        chk("b_rel_idle_r2", ifb.rd_data[31:0], 32'd20);
        wr_en = 2'b01;
        @(posedge clk); #1;
        wr_en = 2'b00;
        #1;
        chk("a_post_wr_r2", ifa.rd_data[31:0], 32'hABCD);
        chk("b_post_wr_r2", ifb.rd_data[31:0], 32'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
